// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
//
// Machine-mode CSR register file. Holds the trap/return state (mstatus MIE/MPIE,
// mepc, mcause, mtval), mtvec, mie, mscratch, the 64-bit mcycle/minstret
// counters and the interrupt-pending logic.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   csr_raddr, csr_wintent   execute-stage read address and write intent
//   csr_rdata, csr_illegal   combinational read result / illegal-access flag
//   wb_en, wb_addr, wb_data  CSR writeback stream (data already merged)
//   instr_retire             one instruction retired this cycle
//   trap_valid, trap_cause,
//   trap_pc, trap_tval       trap entry request and its recorded values
//   mret_valid               MRET executing this cycle
//   irq_ext, irq_timer       interrupt levels shown in mip (MEIP, MTIP)
//   mtvec_out                trap target PC (direct or vectored)
//   mepc_out                 current mepc (MRET target)
//   irq_pending              an enabled interrupt is pending and MIE is set
//
// Strobe semantics: wb_en, trap_valid, mret_valid and instr_retire are
// single-cycle qualifiers with no back-pressure; each one is consumed at the
// clk edge on which it is high. Same-register priority is rst > trap > mret >
// writeback.
// -----------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] csr_raddr,
    input  logic        csr_wintent,
    output logic [31:0] csr_rdata,
    output logic        csr_illegal,
    input  logic        wb_en,
    input  logic [11:0] wb_addr,
    input  logic [31:0] wb_data,
    input  logic        instr_retire,
    input  logic        trap_valid,
    input  logic [31:0] trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret_valid,
    input  logic        irq_ext,
    input  logic        irq_timer,
    output logic [31:0] mtvec_out,
    output logic [31:0] mepc_out,
    output logic        irq_pending
);

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MIE       = 12'h304;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MIP       = 12'h344;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;
    localparam logic [11:0] ADDR_CYCLE     = 12'hC00;
    localparam logic [11:0] ADDR_INSTRET   = 12'hC02;
    localparam logic [11:0] ADDR_CYCLEH    = 12'hC80;
    localparam logic [11:0] ADDR_INSTRETH  = 12'hC82;

    localparam logic [31:0] MISA_VALUE = 32'h4000_0100;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic        mstatus_mie;
    logic        mstatus_mpie;
    logic [31:0] mtvec;
    logic [31:0] mie;
    logic [31:0] mscratch;
    logic [31:0] mepc;
    logic [31:0] mcause;
    logic [31:0] mtval;
    logic [63:0] mcycle;
    logic [63:0] minstret;

    logic [31:0] mstatus_val;
    logic [31:0] mip_val;

    // MPP is hard-wired to machine mode (2'b11).
    assign mstatus_val = {19'b0, 2'b11, 3'b0, mstatus_mpie, 3'b0, mstatus_mie, 3'b0};
    assign mip_val     = {20'b0, irq_ext, 3'b0, irq_timer, 7'b0};

    // ------------------------------------------------------------------
    // Writeback decode: which addresses accept a write and the value the
    // target register holds after that write (field masks applied).
    // ------------------------------------------------------------------
    logic        wb_writable;
    logic [31:0] wb_masked;

    always_comb begin
        wb_writable = 1'b0;
        wb_masked   = wb_data;
        case (wb_addr)
            ADDR_MSTATUS: begin
                wb_writable = 1'b1;
                wb_masked   = (wb_data & 32'h0000_0088) | 32'h0000_1800;
            end
            ADDR_MIE: begin
                wb_writable = 1'b1;
                wb_masked   = wb_data & MIE_MASK;
            end
            ADDR_MTVEC: begin
                wb_writable = 1'b1;
                wb_masked   = {wb_data[31:2], 1'b0, wb_data[0]};
            end
            ADDR_MEPC: begin
                wb_writable = 1'b1;
                wb_masked   = {wb_data[31:2], 2'b00};
            end
            ADDR_MSCRATCH, ADDR_MCAUSE, ADDR_MTVAL,
            ADDR_MCYCLE, ADDR_MCYCLEH, ADDR_MINSTRET, ADDR_MINSTRETH: begin
                wb_writable = 1'b1;
            end
            default: begin
                wb_writable = 1'b0;
            end
        endcase
    end

    logic wb_fire;
    assign wb_fire = wb_en & wb_writable;

    // ------------------------------------------------------------------
    // Read port with same-cycle writeback bypass
    // ------------------------------------------------------------------
    logic        rd_hit;
    logic [31:0] rd_val;

    always_comb begin
        rd_hit = 1'b1;
        rd_val = 32'h0;
        case (csr_raddr)
            ADDR_MSTATUS:                 rd_val = mstatus_val;
            ADDR_MISA:                    rd_val = MISA_VALUE;
            ADDR_MIE:                     rd_val = mie;
            ADDR_MTVEC:                   rd_val = mtvec;
            ADDR_MSCRATCH:                rd_val = mscratch;
            ADDR_MEPC:                    rd_val = mepc;
            ADDR_MCAUSE:                  rd_val = mcause;
            ADDR_MTVAL:                   rd_val = mtval;
            ADDR_MIP:                     rd_val = mip_val;
            ADDR_MCYCLE, ADDR_CYCLE:      rd_val = mcycle[31:0];
            ADDR_MCYCLEH, ADDR_CYCLEH:    rd_val = mcycle[63:32];
            ADDR_MINSTRET, ADDR_INSTRET:  rd_val = minstret[31:0];
            ADDR_MINSTRETH, ADDR_INSTRETH: rd_val = minstret[63:32];
            ADDR_MHARTID:                 rd_val = HART_ID;
            default: begin
                rd_hit = 1'b0;
                rd_val = 32'h0;
            end
        endcase
    end

    always_comb begin
        csr_rdata = rd_val;
        if (wb_fire && (wb_addr == csr_raddr)) begin
            csr_rdata = wb_masked;
        end
        // Address space 0xC00-0xFFF is read-only by encoding.
        csr_illegal = ~rd_hit | (csr_wintent & (csr_raddr[11:10] == 2'b11));
    end

    // ------------------------------------------------------------------
    // Counters: a write to either half replaces that half and drops this
    // cycle's increment; the other half is left untouched.
    // ------------------------------------------------------------------
    logic [63:0] mcycle_next;
    logic [63:0] minstret_next;

    always_comb begin
        mcycle_next   = mcycle + 64'd1;
        minstret_next = minstret + {63'b0, instr_retire};
        if (wb_en && (wb_addr == ADDR_MCYCLE)) begin
            mcycle_next = {mcycle[63:32], wb_data};
        end else if (wb_en && (wb_addr == ADDR_MCYCLEH)) begin
            mcycle_next = {wb_data, mcycle[31:0]};
        end
        if (wb_en && (wb_addr == ADDR_MINSTRET)) begin
            minstret_next = {minstret[63:32], wb_data};
        end else if (wb_en && (wb_addr == ADDR_MINSTRETH)) begin
            minstret_next = {wb_data, minstret[31:0]};
        end
    end

    // ------------------------------------------------------------------
    // Sequential update
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mstatus_mie  <= 1'b0;
            mstatus_mpie <= 1'b0;
            mtvec        <= {RESET_MTVEC[31:2], 1'b0, RESET_MTVEC[0]};
            mie          <= 32'h0;
            mscratch     <= 32'h0;
            mepc         <= 32'h0;
            mcause       <= 32'h0;
            mtval        <= 32'h0;
            mcycle       <= 64'h0;
            minstret     <= 64'h0;
        end else begin
            mcycle   <= mcycle_next;
            minstret <= minstret_next;

            // Registers the trap path never touches always accept writeback.
            if (wb_fire && (wb_addr == ADDR_MIE))      mie      <= wb_masked;
            if (wb_fire && (wb_addr == ADDR_MTVEC))    mtvec    <= wb_masked;
            if (wb_fire && (wb_addr == ADDR_MSCRATCH)) mscratch <= wb_masked;

            if (trap_valid) begin
                mepc         <= {trap_pc[31:2], 2'b00};
                mcause       <= trap_cause;
                mtval        <= trap_tval;
                mstatus_mpie <= mstatus_mie;
                mstatus_mie  <= 1'b0;
            end else begin
                if (wb_fire && (wb_addr == ADDR_MEPC))   mepc   <= wb_masked;
                if (wb_fire && (wb_addr == ADDR_MCAUSE)) mcause <= wb_masked;
                if (wb_fire && (wb_addr == ADDR_MTVAL))  mtval  <= wb_masked;
                if (mret_valid) begin
                    mstatus_mie  <= mstatus_mpie;
                    mstatus_mpie <= 1'b1;
                end else if (wb_fire && (wb_addr == ADDR_MSTATUS)) begin
                    mstatus_mie  <= wb_data[3];
                    mstatus_mpie <= wb_data[7];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Trap vector, MRET target, interrupt pending
    // ------------------------------------------------------------------
    logic [31:0] mtvec_base;
    assign mtvec_base = {mtvec[31:2], 2'b00};

    always_comb begin
        mtvec_out = mtvec_base;
        if (mtvec[0] && trap_cause[31]) begin
            mtvec_out = mtvec_base + {25'b0, trap_cause[4:0], 2'b00};
        end
    end

    assign mepc_out    = mepc;
    assign irq_pending = mstatus_mie & (|(mie & mip_val));

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file
//
// Directed steps followed by a randomized phase. A behavioural model of the
// machine-mode CSRs (plain variables, 64-bit counters held as whole numbers)
// predicts every output; each comparison is an immediate assertion.
// -----------------------------------------------------------------------------
module tb_csr_file;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [11:0] csr_raddr;
    logic        csr_wintent;
    logic [31:0] csr_rdata;
    logic        csr_illegal;
    logic        wb_en;
    logic [11:0] wb_addr;
    logic [31:0] wb_data;
    logic        instr_retire;
    logic        trap_valid;
    logic [31:0] trap_cause;
    logic [31:0] trap_pc;
    logic [31:0] trap_tval;
    logic        mret_valid;
    logic        irq_ext;
    logic        irq_timer;
    logic [31:0] mtvec_out;
    logic [31:0] mepc_out;
    logic        irq_pending;

    csr_file #(
        .RESET_MTVEC(32'h0000_0100),
        .HART_ID    (32'h0000_0005)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_raddr   (csr_raddr),
        .csr_wintent (csr_wintent),
        .csr_rdata   (csr_rdata),
        .csr_illegal (csr_illegal),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .instr_retire(instr_retire),
        .trap_valid  (trap_valid),
        .trap_cause  (trap_cause),
        .trap_pc     (trap_pc),
        .trap_tval   (trap_tval),
        .mret_valid  (mret_valid),
        .irq_ext     (irq_ext),
        .irq_timer   (irq_timer),
        .mtvec_out   (mtvec_out),
        .mepc_out    (mepc_out),
        .irq_pending (irq_pending)
    );

    // ---------------- scoreboard ----------------
    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic        m_mie_en;     // mstatus.MIE
    logic        m_mpie;       // mstatus.MPIE
    logic [31:0] m_mtvec;
    logic [31:0] m_mie_reg;
    logic [31:0] m_mscratch;
    logic [31:0] m_mepc;
    logic [31:0] m_mcause;
    logic [31:0] m_mtval;
    logic [63:0] m_cycle;
    logic [63:0] m_instret;

    function automatic logic m_writable(input logic [11:0] a);
        case (a)
            12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
            12'hB00, 12'hB02, 12'hB80, 12'hB82: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Value a register reads after a write of d.
    function automatic logic [31:0] m_masked(input logic [11:0] a, input logic [31:0] d);
        case (a)
            12'h300: return (d & 32'h88) | 32'h1800;
            12'h304: return d & 32'h888;
            12'h305: return d & ~32'd2;
            12'h341: return d & ~32'd3;
            default: return d;
        endcase
    endfunction

    // {implemented, value} from current model state, ignoring the bypass.
    function automatic logic [32:0] m_plain_read(input logic [11:0] a);
        case (a)
            12'h300: return {1'b1, 32'h1800 | (m_mie_en ? 32'h8 : 32'h0) | (m_mpie ? 32'h80 : 32'h0)};
            12'h301: return {1'b1, 32'h4000_0100};
            12'h304: return {1'b1, m_mie_reg};
            12'h305: return {1'b1, m_mtvec};
            12'h340: return {1'b1, m_mscratch};
            12'h341: return {1'b1, m_mepc};
            12'h342: return {1'b1, m_mcause};
            12'h343: return {1'b1, m_mtval};
            12'h344: return {1'b1, (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0)};
            12'hB00, 12'hC00: return {1'b1, m_cycle[31:0]};
            12'hB80, 12'hC80: return {1'b1, m_cycle[63:32]};
            12'hB02, 12'hC02: return {1'b1, m_instret[31:0]};
            12'hB82, 12'hC82: return {1'b1, m_instret[63:32]};
            12'hF14: return {1'b1, 32'h5};
            default: return 33'h0;
        endcase
    endfunction

    function automatic logic [31:0] m_rdata(input logic [11:0] a);
        logic [32:0] r;
        r = m_plain_read(a);
        if (wb_en && wb_addr == a && m_writable(a)) return m_masked(a, wb_data);
        return r[31:0];
    endfunction

    function automatic logic m_illegal(input logic [11:0] a, input logic wi);
        logic [32:0] r;
        r = m_plain_read(a);
        return !r[32] || (wi && a >= 12'hC00);
    endfunction

    function automatic logic [31:0] m_mtvec_out();
        logic [31:0] base;
        base = m_mtvec & ~32'd3;
        if (m_mtvec[0] && trap_cause[31]) return base + 32'(trap_cause % 32) * 4;
        return base;
    endfunction

    function automatic logic m_irq_pending();
        logic [31:0] mip;
        mip = (irq_ext ? 32'h800 : 32'h0) | (irq_timer ? 32'h80 : 32'h0);
        return m_mie_en && ((m_mie_reg & mip) != 0);
    endfunction

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic m_update();
        logic [63:0] nc;
        logic [63:0] ni;
        if (rst) begin
            m_mie_en = 0; m_mpie = 0; m_mtvec = 32'h100; m_mie_reg = 0;
            m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
            m_cycle = 0; m_instret = 0;
        end else begin
            nc = m_cycle + 1;
            ni = m_instret + (instr_retire ? 64'd1 : 64'd0);
            if (wb_en) begin
                case (wb_addr)
                    12'hB00: nc = {m_cycle[63:32], wb_data};
                    12'hB80: nc = {wb_data, m_cycle[31:0]};
                    12'hB02: ni = {m_instret[63:32], wb_data};
                    12'hB82: ni = {wb_data, m_instret[31:0]};
                    12'h304: m_mie_reg  = m_masked(wb_addr, wb_data);
                    12'h305: m_mtvec    = m_masked(wb_addr, wb_data);
                    12'h340: m_mscratch = wb_data;
                    default: ;
                endcase
            end
            if (trap_valid) begin
                m_mepc   = trap_pc & ~32'd3;
                m_mcause = trap_cause;
                m_mtval  = trap_tval;
                m_mpie   = m_mie_en;
                m_mie_en = 0;
            end else begin
                if (wb_en && wb_addr == 12'h341) m_mepc   = m_masked(wb_addr, wb_data);
                if (wb_en && wb_addr == 12'h342) m_mcause = wb_data;
                if (wb_en && wb_addr == 12'h343) m_mtval  = wb_data;
                if (mret_valid) begin
                    m_mie_en = m_mpie;
                    m_mpie   = 1;
                end else if (wb_en && wb_addr == 12'h300) begin
                    m_mie_en = wb_data[3];
                    m_mpie   = wb_data[7];
                end
            end
            m_cycle   = nc;
            m_instret = ni;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_en = 0; trap_valid = 0; mret_valid = 0; instr_retire = 0;
    endtask

    task automatic wb_write(input logic [11:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        tick();
        wb_en = 0;
    endtask

    task automatic read_check(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_raddr = a; csr_wintent = 0;
        #1;
        check(tag, csr_rdata, exp);
    endtask

    logic [11:0] addr_tab[22] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h340, 12'h341,
                                  12'h342, 12'h343, 12'h344, 12'hB00, 12'hB02, 12'hB80,
                                  12'hB82, 12'hF14, 12'hC00, 12'hC02, 12'hC80, 12'hC82,
                                  12'h7C0, 12'h000, 12'h302, 12'hB01};

    // ---------------- stimulus ----------------
    initial begin
        rst = 1; idle();
        csr_raddr = 0; csr_wintent = 0; wb_addr = 0; wb_data = 0;
        trap_cause = 0; trap_pc = 0; trap_tval = 0; irq_ext = 0; irq_timer = 0;
        tick();
        tick();

        // Reset state (rst still held so the counters sit at zero).
        read_check("reset_mtvec", 12'h305, 32'h0000_0100);
        read_check("reset_mstatus", 12'h300, 32'h0000_1800);
        read_check("reset_mcycle", 12'hB00, 32'h0);
        read_check("unimpl_rdata", 12'h7C0, 32'h0);
        check("unimpl_illegal", {31'b0, csr_illegal}, 32'h1);
        check("reset_irq_pending", {31'b0, irq_pending}, 32'h0);
        check("reset_mepc_out", mepc_out, 32'h0);
        rst = 0;

        // Constant CSRs and read-only write intent.
        read_check("misa", 12'h301, 32'h4000_0100);
        read_check("mhartid", 12'hF14, 32'h5);
        csr_wintent = 1; #1;
        check("ro_wintent_illegal", {31'b0, csr_illegal}, 32'h1);
        csr_raddr = 12'h340; #1;
        check("rw_wintent_legal", {31'b0, csr_illegal}, 32'h0);
        csr_wintent = 0;

        // Same-cycle bypass, then the stored value.
        wb_en = 1; wb_addr = 12'h340; wb_data = 32'hDEAD_BEEF; csr_raddr = 12'h340; #1;
        check("mscratch_bypass", csr_rdata, 32'hDEAD_BEEF);
        tick(); wb_en = 0;
        read_check("mscratch_stored", 12'h340, 32'hDEAD_BEEF);

        wb_write(12'h341, 32'h0000_1003);
        read_check("mepc_align", 12'h341, 32'h0000_1000);
        check("mepc_out", mepc_out, 32'h0000_1000);

        irq_ext = 1; irq_timer = 0;
        wb_write(12'h344, 32'hFFFF_FFFF);
        read_check("mip_ro", 12'h344, 32'h0000_0800);
        irq_ext = 0;

        // Trap entry and MRET.
        wb_write(12'h300, 32'h0000_0008);
        trap_valid = 1; trap_cause = 32'h2; trap_pc = 32'h2006; trap_tval = 32'hBAD;
        tick(); trap_valid = 0;
        read_check("trap_mepc", 12'h341, 32'h0000_2004);
        read_check("trap_mcause", 12'h342, 32'h2);
        read_check("trap_mtval", 12'h343, 32'hBAD);
        read_check("trap_mstatus", 12'h300, 32'h0000_1880);
        mret_valid = 1; tick(); mret_valid = 0;
        read_check("mret_mstatus", 12'h300, 32'h0000_1888);

        // Vectored trap target.
        wb_write(12'h305, 32'h0000_0203);
        read_check("mtvec_bit1", 12'h305, 32'h0000_0201);
        trap_cause = 32'h8000_0007; #1;
        check("mtvec_vectored", mtvec_out, 32'h0000_021C);
        trap_cause = 32'h0000_0003; #1;
        check("mtvec_exception", mtvec_out, 32'h0000_0200);

        // Counter carry, retire counting, write beats increment.
        wb_write(12'hB00, 32'hFFFF_FFFE);
        tick(); tick(); tick();
        read_check("mcycleh_carry", 12'hB80, 32'h1);
        read_check("mcycle_low", 12'hB00, 32'h1);
        read_check("cycle_alias", 12'hC00, 32'h1);
        instr_retire = 1;
        for (int i = 0; i < 5; i++) tick();
        instr_retire = 0;
        read_check("minstret_5", 12'hB02, 32'h5);
        instr_retire = 1;
        wb_write(12'hB02, 32'h0000_1234);
        instr_retire = 0;
        read_check("minstret_write", 12'hB02, 32'h0000_1234);

        // Interrupt pending.
        wb_write(12'h304, 32'hFFFF_FFFF);
        read_check("mie_mask", 12'h304, 32'h0000_0888);
        wb_write(12'h304, 32'h0000_0880);
        wb_write(12'h300, 32'h0000_0008);
        irq_timer = 1; #1;
        check("irq_pending_on", {31'b0, irq_pending}, 32'h1);
        wb_write(12'h300, 32'h0);
        check("irq_pending_off", {31'b0, irq_pending}, 32'h0);

        // Trap + MRET + write to mepc in one cycle: trap wins.
        wb_write(12'h300, 32'h0000_0008);
        trap_valid = 1; mret_valid = 1; trap_cause = 32'h5; trap_pc = 32'h3000; trap_tval = 32'h77;
        wb_en = 1; wb_addr = 12'h341; wb_data = 32'h44;
        tick(); idle();
        read_check("combo_mepc", 12'h341, 32'h0000_3000);
        read_check("combo_mcause", 12'h342, 32'h5);
        read_check("combo_mtval", 12'h343, 32'h77);
        read_check("combo_mstatus", 12'h300, 32'h0000_1880);

        // Reset beats trap, MRET and writeback in the same cycle.
        rst = 1; trap_valid = 1; mret_valid = 1;
        wb_en = 1; wb_addr = 12'h340; wb_data = 32'h1234;
        tick(); idle();
        read_check("rst_mscratch", 12'h340, 32'h0);
        read_check("rst_mepc", 12'h341, 32'h0);
        read_check("rst_mstatus", 12'h300, 32'h0000_1800);
        read_check("rst_mtvec", 12'h305, 32'h0000_0100);
        read_check("rst_mie", 12'h304, 32'h0);
        read_check("rst_mcycle", 12'hB00, 32'h0);
        check("rst_mepc_out", mepc_out, 32'h0);
        rst = 0;

        // Randomized phase against the model.
        for (int i = 0; i < 400; i++) begin
            trap_valid   = ($urandom_range(0, 9) == 0);
            mret_valid   = ($urandom_range(0, 7) == 0);
            wb_en        = ($urandom_range(0, 2) != 0) && !trap_valid && !mret_valid;
            wb_addr      = addr_tab[$urandom_range(0, 21)];
            wb_data      = $urandom;
            instr_retire = $urandom_range(0, 1);
            trap_cause   = $urandom;
            trap_pc      = $urandom;
            trap_tval    = $urandom;
            irq_ext      = $urandom_range(0, 1);
            irq_timer    = $urandom_range(0, 1);
            csr_wintent  = $urandom_range(0, 1);
            csr_raddr    = ($urandom_range(0, 3) == 0) ? wb_addr : addr_tab[$urandom_range(0, 21)];
            #1;
            exp_q.push_back(m_rdata(csr_raddr));
            check("rnd_rdata", csr_rdata, exp_q.pop_front());
            check("rnd_illegal", {31'b0, csr_illegal}, {31'b0, m_illegal(csr_raddr, csr_wintent)});
            check("rnd_mtvec_out", mtvec_out, m_mtvec_out());
            check("rnd_mepc_out", mepc_out, m_mepc);
            check("rnd_irq_pending", {31'b0, irq_pending}, {31'b0, m_irq_pending()});
            tick();
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
